data_memory_split: RTL and testbench
====================================

# data_memory_split

Parametrised, handshaked RISC-V data memory. It serves lb/lbu/lh/lhu/lw and sb/sh/sw using funct3 size encoding and little-endian byte order. Accesses that straddle a word boundary are split into two sequential beats. It sits between the core's load/store unit and a word-organised storage array, and succeeds the single-cycle data memory with a valid/ready request port, a registered response and error signalling.

## Interface
Parameters:
- DEPTH_WORDS, default 256: number of 32-bit words; power of two, ≥2.
- ALLOW_MISALIGNED, default 1:
  - 1: any byte address is legal; straddling accesses are split.
  - 0: any address not a multiple of the access size is an error.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- reset  in  1  asynchronous, active-high; clears control state only.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  3  funct3 code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_wdata  in  32  store data; low bytes are used for b/h.
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  32  extended load data; 0 for stores and errors; holds its value until the next response.
- rsp_error  out  1  qualifies rsp_valid.

## Operation
- Storage is an array of DEPTH_WORDS × 32 bits. Byte k of a word is bits [8k+7:8k].
- Word index = req_addr[AW+1:2], where AW = log2(DEPTH_WORDS); higher address bits are ignored. Index DEPTH_WORDS-1 plus 1 wraps to 0.
- Access size n is 1, 2 or 4 bytes. off = req_addr[1:0]. The access straddles when off+n > 4.
- Errors: no storage change, rsp_error=1, rsp_rdata=0, latency 1. An access is an error when any of these hold:
  - req_size is 011, 110 or 111;
  - a store uses size 100 or 101;
  - ALLOW_MISALIGNED=0 and the address is misaligned.
- Byte-enable writes: only the addressed bytes change. Partial words are never read-modify-written through the port.
- Loads:
  - b and h sign-extend from bit 7 and bit 15 of the assembled value.
  - bu and hu zero-extend.
  - w returns the assembled 4 bytes.
- FSM:
  - IDLE: req_ready=1. On accept, perform the beat-0 access: the write, or the read into a low-byte holding register.
    - If not straddling, go to IDLE and assert rsp_valid next cycle.
    - If straddling, latch the address, size, data and the index+1 (wrapped), then go to SECOND.
  - SECOND: req_ready=0. Perform the beat-1 access on word index+1 (remaining bytes). Go to IDLE with rsp_valid next cycle.
- The storage array is not cleared by reset. Its initial contents are undefined and the bench preloads them hierarchically.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0.
- Non-straddling or error request accepted at edge E0: response registered at E0, valid during cycle E0→E1.
- Straddling request accepted at E0: second beat at E1, response valid during E1→E2, req_ready low during E0→E1.
- Back-to-back: a new request may be accepted on the same edge that makes the previous response visible. Throughput is 1 per cycle non-straddling and 1 per 2 cycles straddling.
- A load after a store to the same bytes, accepted on the next edge, returns the new data (the write has completed at the earlier edge).
- Reset asserted mid-operation (in SECOND):
  - the state returns to IDLE immediately and no response is produced;
  - for a straddling store, the beat-0 bytes remain written and the beat-1 bytes are not written (partial store is documented behaviour).
- Outputs are registered except req_ready, which is decoded from state.

## Test plan
- Preload word1=d4d3d2d1 and word2=e4e3e2e1, then lw @0x4 → rsp_valid one cycle after accept, rdata d4d3d2d1, error 0.
- lw @0x6 (same preload) → req_ready low one cycle, rsp_valid two cycles after accept, rdata e2e1d4d3. Check each extension case:
  - lh @0x7 → ffffe1d4; lhu @0x7 → 0000e1d4;
  - lb @0x5 → ffffffd2; lbu @0x5 → 000000d2.
- Zeroed memory, sw f7f6f5f4 @0x5 → word1=f6f5f400, word2=000000f7. sh @0x6 → word1=f5f40000. sb @0x7 → word1=f4000000.
- Wrap (DEPTH_WORDS=256), sw f7f6f5f4 @0x3FE → word255=f5f40000, word0=0000f7f6. Then lw @0x3FE → f7f6f5f4.
- Error cases:
  - size 011, or a store with size 100 → rsp_error=1, rdata 0, memory unchanged, 1-cycle latency;
  - instance with ALLOW_MISALIGNED=0, lh @0x5 → error, no write.
- Reset pulse during SECOND of sw f7f6f5f4 @0x5 on zeroed memory → word1=f6f5f400, word2=00000000, no rsp_valid, req_ready=1 immediately. The next lw @0x4 completes normally.

Source files
------------

// File: rtl/data_memory_split.sv
// rtl/data_memory_split.sv - handshaked RISC-V data memory with two-beat split of word-straddling accesses
module data_memory_split #(
    parameter int DEPTH_WORDS      = 256,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_IDLE,
        ST_SECOND
    } state_t;

    state_t state;
    state_t state_next;

    // Word storage; deliberately not reset, contents undefined until written.
    logic [31:0] mem [DEPTH_WORDS];

    // Context of a straddling access, captured when beat 0 completes.
    logic          l_write;
    logic [2:0]    l_size;
    logic [1:0]    l_off;
    logic [31:0]   l_wdata;
    logic [AW-1:0] l_idx1;
    logic [31:0]   hold;

    // Request decode (only meaningful while idle).
    logic [AW-1:0] req_idx;
    logic [1:0]    req_off;
    logic [2:0]    req_n;
    logic [1:0]    req_align_mask;
    logic          req_err;
    logic          req_straddle;
    logic          unused_addr_bits;

    // Current beat controls.
    logic          beat_en;
    logic          beat1;
    logic          resp_fire;
    logic          resp_err;
    logic          cur_write;
    logic [2:0]    cur_size;
    logic [2:0]    cur_n;
    logic [1:0]    cur_off;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] cur_idx;
    logic [31:0]   cur_word;
    logic [3:0]    wr_be;
    logic [31:0]   wr_word;
    logic [31:0]   asm_data;
    logic [31:0]   ext_data;

    assign req_idx          = req_addr[AW+1:2];
    assign req_off          = req_addr[1:0];
    assign unused_addr_bits = ^req_addr[31:AW+2];

    // Size decode, legality and straddle detection for the incoming request.
    always_comb begin
        req_n          = 3'd4;
        req_align_mask = 2'b11;
        case (req_size[1:0])
            2'b00:   begin req_n = 3'd1; req_align_mask = 2'b00; end
            2'b01:   begin req_n = 3'd2; req_align_mask = 2'b01; end
            default: begin req_n = 3'd4; req_align_mask = 2'b11; end
        endcase
        req_err = (req_size == 3'b011) || (req_size[2:1] == 2'b11)
                || (req_write && req_size[2])
                || (!ALLOW_MISALIGNED && (|(req_off & req_align_mask)));
        req_straddle = ({2'b00, req_off} + {1'b0, req_n}) > 4'd4;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and beat control decode.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        beat_en    = 1'b0;
        beat1      = 1'b0;
        resp_fire  = 1'b0;
        resp_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        resp_fire = 1'b1;
                        resp_err  = 1'b1;
                    end else begin
                        beat_en = 1'b1;
                        if (req_straddle) begin
                            state_next = ST_SECOND;
                        end else begin
                            resp_fire = 1'b1;
                        end
                    end
                end
            end
            ST_SECOND: begin
                beat_en    = 1'b1;
                beat1      = 1'b1;
                resp_fire  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Select the access context: live request on beat 0, latched copy on beat 1.
    always_comb begin
        cur_write = beat1 ? l_write : req_write;
        cur_size  = beat1 ? l_size  : req_size;
        cur_off   = beat1 ? l_off   : req_off;
        cur_wdata = beat1 ? l_wdata : req_wdata;
        cur_idx   = beat1 ? l_idx1  : req_idx;
        case (cur_size[1:0])
            2'b00:   cur_n = 3'd1;
            2'b01:   cur_n = 3'd2;
            default: cur_n = 3'd4;
        endcase
        cur_word = mem[cur_idx];
    end

    // Map word byte lanes to value bytes for this beat: beat 0 covers lanes off..3,
    // beat 1 covers the leftover value bytes starting at lane 0 of the next word.
    always_comb begin
        wr_be    = 4'b0000;
        wr_word  = 32'h0;
        asm_data = beat1 ? hold : 32'h0;
        for (int p = 0; p < 4; p++) begin
            int bi;
            bi = beat1 ? (p + 4 - int'(cur_off)) : (p - int'(cur_off));
            if (bi >= 0 && bi < int'(cur_n)) begin
                wr_be[p]            = 1'b1;
                wr_word[8*p +: 8]   = cur_wdata[8*bi +: 8];
                asm_data[8*bi +: 8] = cur_word[8*p +: 8];
            end
        end
    end

    // Sign/zero extension of the assembled load value.
    always_comb begin
        ext_data = asm_data;
        case (cur_size)
            3'b000:  ext_data = {{24{asm_data[7]}},  asm_data[7:0]};
            3'b001:  ext_data = {{16{asm_data[15]}}, asm_data[15:0]};
            3'b100:  ext_data = {24'h0, asm_data[7:0]};
            3'b101:  ext_data = {16'h0, asm_data[15:0]};
            default: ext_data = asm_data;
        endcase
    end

    // Byte-enabled store; suppressed while reset is held so an aborted beat never lands.
    always_ff @(posedge clk) begin
        if (!reset && beat_en && cur_write) begin
            for (int p = 0; p < 4; p++) begin
                if (wr_be[p]) begin
                    mem[cur_idx][8*p +: 8] <= wr_word[8*p +: 8];
                end
            end
        end
    end

    // Capture the straddling access context and the beat-0 load bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_write <= 1'b0;
            l_size  <= 3'b000;
            l_off   <= 2'b00;
            l_wdata <= 32'h0;
            l_idx1  <= '0;
            hold    <= 32'h0;
        end else if (state == ST_IDLE && state_next == ST_SECOND) begin
            l_write <= req_write;
            l_size  <= req_size;
            l_off   <= req_off;
            l_wdata <= req_wdata;
            l_idx1  <= req_idx + 1'b1;
            hold    <= asm_data;
        end
    end

    // Registered response; data holds between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_error <= 1'b0;
        end else begin
            rsp_valid <= resp_fire;
            if (resp_fire) begin
                rsp_error <= resp_err;
                rsp_rdata <= (resp_err || cur_write) ? 32'h0 : ext_data;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_split.sv
// tb/tb_data_memory_split.sv - directed-vector bench for data_memory_split
module tb_data_memory_split;
    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        sel_b;

    logic        rdy_a, val_a, err_a;
    logic [31:0] rd_a;
    logic        rdy_b, val_b, err_b;
    logic [31:0] rd_b;

    logic        cur_ready, cur_valid, cur_error;
    logic [31:0] cur_rdata;

    int vectors;
    int miscompares;

    logic [31:0] g_rd;
    logic        g_er;
    int          g_lat;
    logic        g_rdy;

    data_memory_split #(.DEPTH_WORDS(256), .ALLOW_MISALIGNED(1'b1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid && !sel_b),
        .req_ready (rdy_a),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (val_a),
        .rsp_rdata (rd_a),
        .rsp_error (err_a)
    );

    data_memory_split #(.DEPTH_WORDS(256), .ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid && sel_b),
        .req_ready (rdy_b),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (val_b),
        .rsp_rdata (rd_b),
        .rsp_error (err_b)
    );

    assign cur_ready = sel_b ? rdy_b : rdy_a;
    assign cur_valid = sel_b ? val_b : val_a;
    assign cur_error = sel_b ? err_b : err_a;
    assign cur_rdata = sel_b ? rd_b  : rd_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic zero_mem();
        for (int i = 0; i < 256; i++) begin
            dut_a.mem[i] = 32'h0;
            dut_b.mem[i] = 32'h0;
        end
    endtask

    // Issue one request; report response data/error, cycles from accept to
    // response (0 if none within the bound) and req_ready just after accept.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat, output logic rdy_mid);
        int cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rdy_mid   = cur_ready;
        cnt       = 1;
        while (!cur_valid && cnt < 8) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        lat = cur_valid ? cnt : 0;
        rd  = cur_rdata;
        er  = cur_error;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 32'h0;
        req_size    = 3'b010;
        req_wdata   = 32'h0;
        sel_b       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_vec("rst_ready", {31'h0, rdy_a}, 32'h1);
        check_vec("rst_valid", {31'h0, val_a}, 32'h0);
        check_vec("rst_rdata", rd_a, 32'h0);
        check_vec("rst_error", {31'h0, err_a}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Aligned and straddling loads with each extension mode.
        zero_mem();
        dut_a.mem[1] = 32'hd4d3d2d1;
        dut_a.mem[2] = 32'he4e3e2e1;
        do_req(1'b0, 32'h4, 3'b010, 32'h0, g_rd, g_er, g_lat, g_rdy);
        check_vec("lw4_lat", g_lat, 1);
        check_vec("lw4_data", g_rd, 32'hd4d3d2d1);
        check_vec("lw4_err", {31'h0, g_er}, 32'h0);
        do_req(1'b0, 32'h6, 3'b010, 32'h0, g_rd, g_er, g_lat, g_rdy);
        check_vec("lw6_ready_mid", {31'h0, g_rdy}, 32'h0);
        check_vec("lw6_lat", g_lat, 2);
        check_vec("lw6_data", g_rd, 32'he2e1d4d3);
        do_req(1'b0, 32'h7, 3'b001, 32'h0, g_rd, g_er, g_lat, g_rdy);
        check_vec("lh7_data", g_rd, 32'hffffe1d4);
        do_req(1'b0, 32'h7, 3'b101, 32'h0, g_rd, g_er, g_lat, g_rdy);
        check_vec("lhu7_data", g_rd, 32'h0000e1d4);
        do_req(1'b0, 32'h5, 3'b000, 32'h0, g_rd, g_er, g_lat, g_rdy);
        check_vec("lb5_data", g_rd, 32'hffffffd2);
        check_vec("lb5_lat", g_lat, 1);
        do_req(1'b0, 32'h5, 3'b100, 32'h0, g_rd, g_er, g_lat, g_rdy);
        check_vec("lbu5_data", g_rd, 32'h000000d2);

        // Stores with byte enables.
        zero_mem();
        do_req(1'b1, 32'h5, 3'b010, 32'hf7f6f5f4, g_rd, g_er, g_lat, g_rdy);
        check_vec("sw5_lat", g_lat, 2);
        check_vec("sw5_rdata", g_rd, 32'h0);
        check_vec("sw5_w1", dut_a.mem[1], 32'hf6f5f400);
        check_vec("sw5_w2", dut_a.mem[2], 32'h000000f7);
        zero_mem();
        do_req(1'b1, 32'h6, 3'b001, 32'hf7f6f5f4, g_rd, g_er, g_lat, g_rdy);
        check_vec("sh6_w1", dut_a.mem[1], 32'hf5f40000);
        check_vec("sh6_w2", dut_a.mem[2], 32'h0);
        zero_mem();
        do_req(1'b1, 32'h7, 3'b000, 32'hf7f6f5f4, g_rd, g_er, g_lat, g_rdy);
        check_vec("sb7_w1", dut_a.mem[1], 32'hf4000000);

        // Index wrap from the last word to word 0.
        zero_mem();
        do_req(1'b1, 32'h3fe, 3'b010, 32'hf7f6f5f4, g_rd, g_er, g_lat, g_rdy);
        check_vec("wrap_w255", dut_a.mem[255], 32'hf5f40000);
        check_vec("wrap_w0", dut_a.mem[0], 32'h0000f7f6);
        do_req(1'b0, 32'h3fe, 3'b010, 32'h0, g_rd, g_er, g_lat, g_rdy);
        check_vec("wrap_lw", g_rd, 32'hf7f6f5f4);

        // Illegal size codes.
        dut_a.mem[1] = 32'hd4d3d2d1;
        do_req(1'b0, 32'h4, 3'b011, 32'h0, g_rd, g_er, g_lat, g_rdy);
        check_vec("sz011_err", {31'h0, g_er}, 32'h1);
        check_vec("sz011_rdata", g_rd, 32'h0);
        check_vec("sz011_lat", g_lat, 1);
        do_req(1'b1, 32'h4, 3'b100, 32'h11223344, g_rd, g_er, g_lat, g_rdy);
        check_vec("sbu_err", {31'h0, g_er}, 32'h1);
        check_vec("sbu_lat", g_lat, 1);
        check_vec("sbu_mem", dut_a.mem[1], 32'hd4d3d2d1);

        // Alignment-enforcing instance.
        sel_b = 1'b1;
        dut_b.mem[1] = 32'h8899aabb;
        do_req(1'b0, 32'h5, 3'b001, 32'h0, g_rd, g_er, g_lat, g_rdy);
        check_vec("mis_lh_err", {31'h0, g_er}, 32'h1);
        check_vec("mis_lh_rdata", g_rd, 32'h0);
        do_req(1'b1, 32'h5, 3'b001, 32'h12345678, g_rd, g_er, g_lat, g_rdy);
        check_vec("mis_sh_err", {31'h0, g_er}, 32'h1);
        check_vec("mis_sh_mem", dut_b.mem[1], 32'h8899aabb);
        do_req(1'b0, 32'h6, 3'b101, 32'h0, g_rd, g_er, g_lat, g_rdy);
        check_vec("al_lhu_err", {31'h0, g_er}, 32'h0);
        check_vec("al_lhu_data", g_rd, 32'h00008899);
        sel_b = 1'b0;

        // Reset during the second beat of a straddling store.
        zero_mem();
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h5;
        req_size  = 3'b010;
        req_wdata = 32'hf7f6f5f4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_vec("rst2_ready_second", {31'h0, rdy_a}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check_vec("rst2_ready_now", {31'h0, rdy_a}, 32'h1);
        check_vec("rst2_valid_now", {31'h0, val_a}, 32'h0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_vec("rst2_valid_e1", {31'h0, val_a}, 32'h0);
        @(posedge clk);
        #1;
        check_vec("rst2_valid_e2", {31'h0, val_a}, 32'h0);
        check_vec("rst2_w1", dut_a.mem[1], 32'hf6f5f400);
        check_vec("rst2_w2", dut_a.mem[2], 32'h0);
        do_req(1'b0, 32'h4, 3'b010, 32'h0, g_rd, g_er, g_lat, g_rdy);
        check_vec("rst2_lw_lat", g_lat, 1);
        check_vec("rst2_lw_data", g_rd, 32'hf6f5f400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
